// File: rtl/video_bg_fetch_sequencer_if.sv
// VRAM read bus between the background fetch sequencer and video memory.
// Ports: addr[13:0]/read driven by the sequencer (master), data[7:0] returned by memory (slave).
interface video_bg_fetch_sequencer_if;
    logic [13:0] addr;
    logic        read;
    logic [7:0]  data;

    modport master (output addr, output read, input data);
    modport slave  (input addr, input read, output data);
endinterface

// File: rtl/video_bg_fetch_sequencer.sv
// Background fetch sequencer: owns VRAM address v, issues NT/AT/PT-lo/PT-hi slots per 8 dots.
// Ports: I_clock, I_reset (async low), dot/line timing, PPUCTRL/MASK, t, v-write pulse,
//        vram bus (master), O_control strobes, O_at_shift, O_shr_tile, O_v.
module video_bg_fetch_sequencer #(
    parameter int LAST_LINE    = 261,
    parameter int PT_HI_OFFSET = 8
) (
    input  logic                          I_clock,
    input  logic                          I_reset,
    input  logic [8:0]                    I_dot,
    input  logic [8:0]                    I_line,
    input  logic [7:0]                    I_ppuctrl,
    input  logic [7:0]                    I_ppumask,
    input  logic [14:0]                   I_t,
    input  logic                          I_v_write,
    video_bg_fetch_sequencer_if.master    vram,
    output logic [15:0]                   O_control,
    output logic [1:0]                    O_at_shift,
    output logic                          O_shr_tile,
    output logic [14:0]                   O_v
);
    localparam logic [8:0] LL = 9'(LAST_LINE);
    localparam int CTRL_AT = 0;
    localparam int CTRL_LO = 1;
    localparam int CTRL_HI = 2;

    typedef enum logic [3:0] {
        S_IDLE, S_NT, S_NT_LAT, S_AT, S_AT_STB,
        S_LO, S_LO_STB, S_HI, S_HI_STB
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] v_q, v_d;
    logic [7:0]  nt_q, nt_d;
    logic [13:0] addr_q, addr_d;
    logic [1:0]  at_q, at_d;
    logic        shr_q, shr_d;

    logic        ren;
    logic        in_win;
    logic        shr_win;
    logic [2:0]  phase;
    logic [13:0] pt_addr;
    logic        unused_bits;

    function automatic logic [14:0] inc_x(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (v[4:0] == 5'd31) begin
            r[4:0] = 5'd0;
            r[10]  = ~v[10];
        end else begin
            r[4:0] = v[4:0] + 5'd1;
        end
        return r;
    endfunction

    function automatic logic [14:0] inc_y(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (v[14:12] != 3'd7) begin
            r[14:12] = v[14:12] + 3'd1;
        end else begin
            r[14:12] = 3'd0;
            if (v[9:5] == 5'd29) begin
                r[9:5] = 5'd0;
                r[11]  = ~v[11];
            end else if (v[9:5] == 5'd31) begin
                // rows 30/31 hold attribute data: wrap without changing nametable
                r[9:5] = 5'd0;
            end else begin
                r[9:5] = v[9:5] + 5'd1;
            end
        end
        return r;
    endfunction

    assign ren     = (|I_ppumask[4:3]) && (I_line <= 9'd239 || I_line == LL);
    assign phase   = I_dot[2:0] - 3'd1;
    assign in_win  = (I_dot >= 9'd1 && I_dot <= 9'd256) ||
                     (I_dot >= 9'd321 && I_dot <= 9'd336);
    // dots 257/337 are phase 0 outside the window: they close the previous slot
    assign shr_win = (I_dot >= 9'd9 && I_dot <= 9'd257) ||
                     (I_dot >= 9'd329 && I_dot <= 9'd337);
    assign pt_addr = {1'b0, I_ppuctrl[4], nt_q, 1'b0, v_q[14:12]};
    assign unused_bits = ^{I_ppuctrl[7:5], I_ppuctrl[3:0],
                           I_ppumask[7:5], I_ppumask[2:0]};

    always_comb begin
        state_d = S_IDLE;
        if (ren && in_win) begin
            unique case (phase)
                3'd0: state_d = S_NT;
                3'd1: state_d = S_NT_LAT;
                3'd2: state_d = S_AT;
                3'd3: state_d = S_AT_STB;
                3'd4: state_d = S_LO;
                3'd5: state_d = S_LO_STB;
                3'd6: state_d = S_HI;
                3'd7: state_d = S_HI_STB;
            endcase
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        v_d    = v_q;
        nt_d   = nt_q;
        addr_d = addr_q;
        at_d   = at_q;
        shr_d  = 1'b0;
        case (state_d)
            S_NT:     addr_d = {2'b10, v_q[11:0]};
            S_NT_LAT: nt_d = vram.data;
            S_AT: begin
                addr_d = {2'b10, v_q[11:10], 4'b1111, v_q[9:7], v_q[4:2]};
                at_d   = {v_q[6], v_q[1]};
            end
            S_LO:     addr_d = pt_addr;
            S_HI:     addr_d = pt_addr + 14'(PT_HI_OFFSET);
            S_HI_STB: v_d = inc_x(v_q);
            default:  ;
        endcase
        if (ren) begin
            // dot 256 applies coarse-X first (above), then the Y step
            if (I_dot == 9'd256) begin
                v_d = inc_y(v_d);
            end
            if (I_dot == 9'd257) begin
                v_d[10]  = I_t[10];
                v_d[4:0] = I_t[4:0];
            end
            if (I_line == LL && I_dot >= 9'd280 && I_dot <= 9'd304) begin
                v_d[14:11] = I_t[14:11];
                v_d[9:5]   = I_t[9:5];
            end
            shr_d = (phase == 3'd0) && shr_win;
        end
        if (I_v_write) begin
            v_d = I_t;
        end
        if (!ren) begin
            addr_d = v_d[13:0];
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            v_q    <= '0;
            nt_q   <= '0;
            addr_q <= '0;
            at_q   <= '0;
            shr_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            nt_q   <= nt_d;
            addr_q <= addr_d;
            at_q   <= at_d;
            shr_q  <= shr_d;
        end
    end

    always_comb begin
        O_control          = '0;
        O_control[CTRL_AT] = (state_q == S_AT_STB);
        O_control[CTRL_LO] = (state_q == S_LO_STB);
        O_control[CTRL_HI] = (state_q == S_HI_STB);
    end

    assign vram.addr  = addr_q;
    assign vram.read  = state_q inside {S_NT, S_AT, S_LO, S_HI};
    assign O_at_shift = at_q;
    assign O_shr_tile = shr_q;
    assign O_v        = v_q;
endmodule

// File: tb/tb_video_bg_fetch_sequencer.sv
// Directed bench for video_bg_fetch_sequencer: slot table plus v-update corner sequences.
// Drives inputs 1ns after each rising edge and samples there, so each check sees the dot just clocked.
module tb_video_bg_fetch_sequencer;
    logic        clk;
    logic        rst_n;
    logic [8:0]  dot;
    logic [8:0]  line;
    logic [7:0]  ppuctrl;
    logic [7:0]  ppumask;
    logic [14:0] t;
    logic        v_write;
    logic [15:0] control;
    logic [1:0]  at_shift;
    logic        shr_tile;
    logic [14:0] v;

    video_bg_fetch_sequencer_if vram ();

    video_bg_fetch_sequencer dut (
        .I_clock    (clk),
        .I_reset    (rst_n),
        .I_dot      (dot),
        .I_line     (line),
        .I_ppuctrl  (ppuctrl),
        .I_ppumask  (ppumask),
        .I_t        (t),
        .I_v_write  (v_write),
        .vram       (vram),
        .O_control  (control),
        .O_at_shift (at_shift),
        .O_shr_tile (shr_tile),
        .O_v        (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic [13:0] addr;
        logic        read;
        logic [15:0] ctrl;
        logic        shr;
        logic [14:0] v;
    } vec_t;

    vec_t vecs [9];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int d);
        dot = 9'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic write_v(input int d, input logic [14:0] val);
        t       = val;
        v_write = 1'b1;
        step(d);
        v_write = 1'b0;
    endtask

    initial begin
        logic quiet;
        vecs[0] = '{1, 14'h2000, 1'b1, 16'h0000, 1'b0, 15'h0000};
        vecs[1] = '{2, 14'h0000, 1'b0, 16'h0000, 1'b0, 15'h0000};
        vecs[2] = '{3, 14'h23C0, 1'b1, 16'h0000, 1'b0, 15'h0000};
        vecs[3] = '{4, 14'h0000, 1'b0, 16'h0001, 1'b0, 15'h0000};
        vecs[4] = '{5, 14'h1240, 1'b1, 16'h0000, 1'b0, 15'h0000};
        vecs[5] = '{6, 14'h0000, 1'b0, 16'h0002, 1'b0, 15'h0000};
        vecs[6] = '{7, 14'h1248, 1'b1, 16'h0000, 1'b0, 15'h0000};
        vecs[7] = '{8, 14'h0000, 1'b0, 16'h0004, 1'b0, 15'h0001};
        vecs[8] = '{9, 14'h2001, 1'b1, 16'h0000, 1'b1, 15'h0001};

        rst_n     = 1'b0;
        dot       = '0;
        line      = '0;
        ppuctrl   = 8'h10;
        ppumask   = 8'h18;
        t         = '0;
        v_write   = 1'b0;
        vram.data = 8'h24;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {control, vram.read, vram.addr, at_shift, shr_tile, v}, 64'd0);
        rst_n = 1'b1;

        write_v(0, 15'h0000);
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].d);
            chk($sformatf("slot_dot%0d", vecs[i].d),
                {shr_tile, vram.read, control, v},
                {vecs[i].shr, vecs[i].read, vecs[i].ctrl, vecs[i].v});
            if (vecs[i].read)
                chk($sformatf("slot_addr_dot%0d", vecs[i].d), vram.addr, vecs[i].addr);
        end

        write_v(0, 15'h0042);
        for (int d = 1; d <= 3; d++) step(d);
        chk("at_shift", at_shift, 2'b11);

        write_v(0, 15'h001F);
        for (int d = 1; d <= 8; d++) step(d);
        chk("cx_wrap", v, 15'h0400);

        write_v(0, 15'h0000);
        for (int d = 1; d <= 7; d++) step(d);
        write_v(8, 15'h1234);
        chk("vwrite_over_inc", v, 15'h1234);

        write_v(255, 15'h73A5);
        step(256);
        chk("y_cy29_wrap", v, 15'h0806);
        t = 15'h0415;
        step(257);
        chk("hcopy_257", v, 15'h0C15);
        chk("shr_dot257", shr_tile, 1'b1);

        write_v(255, 15'h7BE0);
        step(256);
        chk("y_cy31_wrap", v, 15'h0801);

        write_v(255, 15'h2000);
        step(256);
        chk("y_fine_inc", v, 15'h3001);

        ppumask = 8'h00;
        write_v(0, 15'h1234);
        quiet = 1'b1;
        for (int d = 1; d <= 340; d++) begin
            step(d);
            if (vram.read || control != 16'h0 || shr_tile) quiet = 1'b0;
        end
        chk("mask_off_quiet", quiet, 1'b1);
        chk("mask_off_v", v, 15'h1234);
        chk("mask_off_addr", vram.addr, 14'h1234);

        ppumask = 8'h18;
        line    = 9'd261;
        write_v(0, 15'h0000);
        t = 15'h7BE0;
        for (int d = 1; d <= 304; d++) begin
            step(d);
            if (d == 257) chk("l261_hcopy", v, 15'h1000);
            if (d == 279) chk("l261_pre_vcopy", v, 15'h1000);
            if (d == 280) chk("l261_vcopy_280", v, 15'h7BE0);
        end
        chk("l261_vcopy_304", v, 15'h7BE0);

        line = 9'd0;
        write_v(0, 15'h0000);
        for (int d = 1; d <= 100; d++) step(d);
        chk("pre_reset_at_strobe", control, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_fetch",
            {control, vram.read, vram.addr, at_shift, shr_tile, v}, 64'd0);
        #2;
        rst_n = 1'b1;
        step(101);
        chk("restart_pt_lo", {vram.read, vram.addr}, {1'b1, 14'h1000});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
